wrport_ctrl: RTL and testbench

WRPORT_CTRL -- requirements
Module: wrport_ctrl

---
 rtl/wrport_ctrl.sv | 106 ++++++++++
 tb/tb_wrport_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrport_ctrl.sv
// Write-side controller for a dual-clock FIFO: assembles serial bits LSB-first into words,
// commits them to the shared RAM and maintains the Gray-coded write pointer.
module wrport_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  wrclk,
    input  logic                  wrrst_n,
    input  logic                  a,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  full
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        st_fill,
        st_commit
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         bitcnt_q, bitcnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH:0]   wptr_bin_q, wptr_bin_d;
    logic [ADDR_WIDTH:0]   wptr_gray_q, wptr_gray_d;

    logic                  accept;
    logic                  last_bit;
    logic [CW:0]           cnt_inc;

    assign a_ready  = (state_q == st_fill);
    assign accept   = a_valid && a_ready;
    assign last_bit = accept && (bitcnt_q == CW'(DATA_WIDTH - 1));
    // Bit count after this cycle's accept; one extra bit so a full word never reads as zero.
    assign cnt_inc  = {1'b0, bitcnt_q} + {{CW{1'b0}}, accept};

    // Full when the writer is exactly one lap ahead of the reader.
    assign full  = (wptr_gray_q == {~rptr_gray[ADDR_WIDTH:ADDR_WIDTH-1],
                                    rptr_gray[ADDR_WIDTH-2:0]});
    assign wen   = (state_q == st_commit) && !full;
    assign waddr = wptr_bin_q[ADDR_WIDTH-1:0];
    assign wdata = word_q;
    assign wptr_gray = wptr_gray_q;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        word_d     = word_q;
        wptr_bin_d = wptr_bin_q;

        unique case (state_q)
            st_fill: begin
                if (accept) begin
                    word_d[bitcnt_q] = a;
                    bitcnt_d         = cnt_inc[CW-1:0];
                end
                if (last_bit) begin
                    // A completed word wins over a same-cycle flush: no padding.
                    bitcnt_d = '0;
                    state_d  = st_commit;
                end else if (flush && (cnt_inc != '0)) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if ((CW + 1)'(i) >= cnt_inc) begin
                            word_d[i] = 1'b0;
                        end
                    end
                    bitcnt_d = '0;
                    state_d  = st_commit;
                end
            end
            st_commit: begin
                if (wen) begin
                    wptr_bin_d = wptr_bin_q + PTR_ONE;
                    state_d    = st_fill;
                end
            end
        endcase
    end

    assign wptr_gray_d = wptr_bin_d ^ (wptr_bin_d >> 1);

    always_ff @(posedge wrclk or negedge wrrst_n) begin
        if (!wrrst_n) begin
            state_q     <= st_fill;
            bitcnt_q    <= '0;
            word_q      <= '0;
            wptr_bin_q  <= '0;
            wptr_gray_q <= '0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            word_q      <= word_d;
            wptr_bin_q  <= wptr_bin_d;
            wptr_gray_q <= wptr_gray_d;
        end
    end

endmodule

// File: tb/tb_wrport_ctrl.sv
// Scoreboard bench for wrport_ctrl: stimulus pushes expected RAM writes, a negedge monitor
// pops and compares them on every wen and checks Gray-adjacency of the write pointer.
module tb_wrport_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          wrclk = 1'b0;
    logic          wrrst_n;
    logic          a;
    logic          a_valid;
    logic          a_ready;
    logic          flush;
    logic [AW:0]   rptr_gray;
    logic [AW:0]   wptr_gray;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          full;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_ptr = 0;
    logic [AW:0] prev_gray = '0;

    wrport_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .wrclk    (wrclk),
        .wrrst_n  (wrrst_n),
        .a        (a),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .flush    (flush),
        .rptr_gray(rptr_gray),
        .wptr_gray(wptr_gray),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .full     (full)
    );

    always #5 wrclk = ~wrclk;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every wen must match the oldest expected write.
    always @(negedge wrclk) begin
        if (wrrst_n) begin
            if (wen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wen: waddr=0x%0h wdata=0x%0h, expected no write at %0t",
                             waddr, wdata, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wen_waddr", 32'(waddr), 32'(mon_e.addr));
                    chk("wen_wdata", 32'(wdata), 32'(mon_e.data));
                end
            end
            if (wptr_gray !== prev_gray) begin
                chk("gray_adjacent", 32'($countones(wptr_gray ^ prev_gray)), 32'd1);
            end
        end
        prev_gray = wptr_gray;
    end

    task automatic push_word(input logic [DW-1:0] d);
        exp_q.push_back('{addr: AW'(exp_ptr), data: d});
        exp_ptr++;
    endtask

    task automatic send_bit(input logic b, input logic fl);
        int n;
        a       = b;
        flush   = fl;
        a_valid = 1'b1;
        n       = 0;
        @(negedge wrclk);
        while (!a_ready && n < 200) begin
            n++;
            @(negedge wrclk);
        end
        if (!a_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: a_ready=0, expected 1 within 200 cycles at %0t", $time);
        end
        @(posedge wrclk);
        #1;
        a_valid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(d[i], 1'b0);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge wrclk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge wrclk);
        #1;
    endtask

    task automatic rst_checks();
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_wptr_gray", 32'(wptr_gray), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
    endtask

    // Reset asserted between clock edges to exercise the asynchronous path.
    task automatic do_reset();
        @(posedge wrclk);
        #1;
        a_valid   = 1'b0;
        flush     = 1'b0;
        wrrst_n   = 1'b0;
        rptr_gray = '0;
        #2;
        rst_checks();
        chk("rst_no_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        exp_ptr = 0;
        repeat (2) @(posedge wrclk);
        @(negedge wrclk);
        wrrst_n = 1'b1;
        @(posedge wrclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        wrrst_n   = 1'b1;
        a         = 1'b0;
        a_valid   = 1'b0;
        flush     = 1'b0;
        rptr_gray = '0;
        #1;
        wrrst_n = 1'b0;
        #2;
        rst_checks();
        repeat (2) @(posedge wrclk);
        @(negedge wrclk);
        wrrst_n = 1'b1;
        @(posedge wrclk);
        #1;

        // Full word 1,0,1,1,0,0,1,0 -> 0x4D at address 0, one-cycle commit latency.
        push_word(8'h4D);
        send_word(8'h4D, 8);
        @(negedge wrclk);
        chk("lat_wen", 32'(wen), 32'd1);
        chk("lat_a_ready", 32'(a_ready), 32'd0);
        wait_drain();
        chk("gray_w1", 32'(wptr_gray), 32'h01);

        // Three ones then a separate flush -> 0x07.
        push_word(8'h07);
        send_word(8'h07, 3);
        @(negedge wrclk);
        chk("no_early_wen", 32'(wen), 32'd0);
        flush = 1'b1;
        @(posedge wrclk);
        #1;
        flush = 1'b0;
        @(negedge wrclk);
        chk("flush_lat_wen", 32'(wen), 32'd1);
        wait_drain();
        chk("gray_w2", 32'(wptr_gray), 32'h03);

        // Flush coinciding with the third accepted bit -> 0x06.
        push_word(8'h06);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        wait_drain();
        chk("gray_w3", 32'(wptr_gray), 32'h02);

        // Flush with the completing bit is ignored: exactly one unpadded write.
        push_word(8'hA5);
        send_word(8'hA5, 7);
        send_bit(1'b1, 1'b1);
        wait_drain();
        chk("gray_w4", 32'(wptr_gray), 32'h06);

        // Idle flush with no bits collected does nothing.
        flush = 1'b1;
        repeat (3) begin
            @(negedge wrclk);
            chk("idle_flush_wen", 32'(wen), 32'd0);
            chk("idle_flush_ready", 32'(a_ready), 32'd1);
        end
        @(posedge wrclk);
        #1;
        flush = 1'b0;
        chk("idle_flush_gray", 32'(wptr_gray), 32'h06);
        push_word(8'h3C);
        send_word(8'h3C, 8);
        wait_drain();
        chk("gray_w5", 32'(wptr_gray), 32'h07);

        // Reset mid-word discards the partial word.
        send_word(8'h1F, 5);
        do_reset();
        push_word(8'hFF);
        send_word(8'hFF, 8);
        @(negedge wrclk);
        chk("post_rst_lat_wen", 32'(wen), 32'd1);
        wait_drain();
        chk("post_rst_gray", 32'(wptr_gray), 32'h01);

        // Fill all 16 entries against a stalled reader.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push_word(8'(i * 29 + 7));
            send_word(8'(i * 29 + 7), 8);
        end
        wait_drain();
        chk("full_after_16", 32'(full), 32'd1);
        chk("gray_after_16", 32'(wptr_gray), 32'h18);
        push_word(8'hC3);
        send_word(8'hC3, 8);
        repeat (3) begin
            @(negedge wrclk);
            chk("hold_wen", 32'(wen), 32'd0);
            chk("hold_a_ready", 32'(a_ready), 32'd0);
            chk("hold_waddr", 32'(waddr), 32'd0);
            chk("hold_wdata", 32'(wdata), 32'hC3);
        end
        chk("hold_pending", 32'(exp_q.size()), 32'd1);
        @(posedge wrclk);
        #1;
        rptr_gray = 5'h01;
        @(negedge wrclk);
        chk("release_wen", 32'(wen), 32'd1);
        wait_drain();
        chk("gray_after_17", 32'(wptr_gray), 32'h19);
        chk("full_again", 32'(full), 32'd1);

        // Reset while a word waits in COMMIT: it must never be written.
        send_word(8'h5A, 8);
        repeat (2) begin
            @(negedge wrclk);
            chk("pend_wen", 32'(wen), 32'd0);
        end
        do_reset();

        // 40 words with the reader tracking the writer: address wraps twice.
        for (int i = 0; i < 40; i++) begin
            rptr_gray = bin2gray((AW + 1)'(i));
            push_word(8'(i * 7 + 1));
            send_word(8'(i * 7 + 1), 8);
        end
        wait_drain();
        chk("gray_after_40", 32'(wptr_gray), 32'h0C);
        chk("full_after_40", 32'(full), 32'd0);

        repeat (3) @(negedge wrclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
